// File: rtl/cpu_core_if.sv
// Bus between the instruction sequencer and the decoder/datapath side:
// flat instruction RAM, per-instruction control strobes and the
// registered sequencer state.
interface cpu_core_if #(
    parameter int RAM_SIZE = 4
);
    logic [RAM_SIZE*32-1:0] ram;
    logic                   inst_condition;
    logic                   end_inst;
    logic                   jmp_inst;
    logic                   hlt_inst;
    logic [7:0]             jmp_address;
    logic [31:0]            ir;
    logic [15:0]            clks;
    logic [7:0]             pc;
    logic [1:0]             state;

    // Datapath / memory side: drives RAM and control, observes the sequencer.
    modport master (
        output ram, inst_condition, end_inst, jmp_inst, hlt_inst, jmp_address,
        input  ir, clks, pc, state
    );

    // Sequencer side.
    modport slave (
        input  ram, inst_condition, end_inst, jmp_inst, hlt_inst, jmp_address,
        output ir, clks, pc, state
    );
endinterface

// File: rtl/cpu_core.sv
// Instruction sequencer: fetches a 32-bit word into IR, walks a one-hot
// T-state counter while the external datapath executes, then advances the
// PC sequentially, by jump or by skip. HALT is left only through reset.
module cpu_core #(
    parameter int RAM_SIZE = 4
) (
    input  logic      clk,
    input  logic      reset,
    cpu_core_if.slave bus
);
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        HALT    = 2'b11
    } state_t;

    localparam logic [7:0] LAST_PC = 8'(RAM_SIZE - 1);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d, next_pc;
    logic [31:0] ir_q, ir_d;
    logic [15:0] clks_q, clks_d;

    // Full 256-entry view of the RAM; addresses past RAM_SIZE read as zero,
    // so an out-of-range jump fetches a null instruction.
    logic [31:0] words [256];
    for (genvar i = 0; i < 256; i++) begin : g_word
        if (i < RAM_SIZE) begin : g_in
            assign words[i] = bus.ram[i*32 +: 32];
        end else begin : g_out
            assign words[i] = 32'h0;
        end
    end

    // Sequential PC wraps at the last RAM word; beyond RAM it just counts mod 256.
    always_comb begin
        if (pc_q == LAST_PC) next_pc = 8'h00;
        else                 next_pc = pc_q + 8'd1;
    end

    // Next-state and datapath update for each sequencer phase.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        clks_d  = clks_q;
        case (state_q)
            FETCH: begin
                ir_d    = words[pc_q];
                clks_d  = 16'h0001;
                state_d = DECODE;
            end
            DECODE: begin
                if (bus.inst_condition) begin
                    clks_d  = clks_q << 1;
                    state_d = EXECUTE;
                end else begin
                    pc_d    = next_pc;
                    clks_d  = 16'h0000;
                    state_d = FETCH;
                end
            end
            EXECUTE: begin
                if (bus.hlt_inst) begin
                    clks_d  = 16'h0000;
                    state_d = HALT;
                end else if (bus.end_inst) begin
                    pc_d    = bus.jmp_inst ? bus.jmp_address : next_pc;
                    clks_d  = 16'h0000;
                    state_d = FETCH;
                end else if (clks_q[15]) begin
                    // Counter would shift out: force the instruction to end.
                    pc_d    = next_pc;
                    clks_d  = 16'h0000;
                    state_d = FETCH;
                end else begin
                    clks_d  = clks_q << 1;
                end
            end
            HALT: begin
                clks_d = 16'h0000;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 32'h0;
            clks_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            clks_q  <= clks_d;
        end
    end

    assign bus.state = state_q;
    assign bus.pc    = pc_q;
    assign bus.ir    = ir_q;
    assign bus.clks  = clks_q;
endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: the driver applies one input vector per
// cycle and queues the hand-computed register state expected after that
// edge; the monitor pops and compares after every rising edge.
module tb_cpu_core;
    localparam int RAM_SIZE = 4;

    typedef struct packed {
        logic [1:0]  st;
        logic [7:0]  pc;
        logic [31:0] ir;
        logic [15:0] clks;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    exp_t sb_q[$];

    cpu_core_if #(.RAM_SIZE(RAM_SIZE)) bus ();

    cpu_core #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W0 = 32'h00112233;
    localparam logic [31:0] W1 = 32'h44556677;
    localparam logic [31:0] W2 = 32'h8899AABB;
    localparam logic [31:0] W3 = 32'hCCDDEEFF;

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = '{st: bus.state, pc: bus.pc, ir: bus.ir, clks: bus.clks};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got state=%b pc=%h ir=%h clks=%h, expected state=%b pc=%h ir=%h clks=%h",
                     name, a.st, a.pc, a.ir, a.clks, e.st, e.pc, e.ir, e.clks);
        end
    endtask

    // Drive one vector before the next rising edge and queue its expected result.
    task automatic step(input logic c, input logic en, input logic j, input logic h,
                        input logic [7:0] ja, input logic [1:0] st, input logic [7:0] pc,
                        input logic [31:0] ir, input logic [15:0] ck);
        @(negedge clk);
        bus.inst_condition = c;
        bus.end_inst       = en;
        bus.jmp_inst       = j;
        bus.hlt_inst       = h;
        bus.jmp_address    = ja;
        sb_q.push_back('{st: st, pc: pc, ir: ir, clks: ck});
    endtask

    task automatic drain();
        int budget = 20;
        while (sb_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: one comparison per edge that has a queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                vec_no++;
                compare($sformatf("vec%0d", vec_no), e);
            end
        end
    end

    initial begin
        bus.ram            = {W3, W2, W1, W0};
        bus.inst_condition = 1'b0;
        bus.end_inst       = 1'b0;
        bus.jmp_inst       = 1'b0;
        bus.hlt_inst       = 1'b0;
        bus.jmp_address    = 8'h00;

        repeat (2) @(posedge clk);
        #2;
        compare("reset_state", '{st: 2'b00, pc: 8'h00, ir: 32'h0, clks: 16'h0});
        reset = 1'b1;

        // Sequential run over all four words, pc wraps 3 -> 0.
        step(1, 1, 0, 0, 8'h00, 2'b01, 8'h00, W0, 16'h0001);
        step(1, 1, 0, 0, 8'h00, 2'b10, 8'h00, W0, 16'h0002);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h01, W0, 16'h0000);
        step(1, 1, 0, 0, 8'h00, 2'b01, 8'h01, W1, 16'h0001);
        step(1, 1, 0, 0, 8'h00, 2'b10, 8'h01, W1, 16'h0002);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h02, W1, 16'h0000);
        step(1, 1, 0, 0, 8'h00, 2'b01, 8'h02, W2, 16'h0001);
        step(1, 1, 0, 0, 8'h00, 2'b10, 8'h02, W2, 16'h0002);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h03, W2, 16'h0000);
        step(1, 1, 0, 0, 8'h00, 2'b01, 8'h03, W3, 16'h0001);
        step(1, 1, 0, 0, 8'h00, 2'b10, 8'h03, W3, 16'h0002);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h00, W3, 16'h0000);
        step(1, 1, 0, 0, 8'h00, 2'b01, 8'h00, W0, 16'h0001);

        // Multi-step execute: three extra EXECUTE cycles, pc advances once.
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h00, W0, 16'h0002);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h00, W0, 16'h0004);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h00, W0, 16'h0008);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h00, W0, 16'h0010);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h01, W0, 16'h0000);

        // Walk to pc=2, then skip it (end_inst high must not matter in DECODE).
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h01, W1, 16'h0001);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h01, W1, 16'h0002);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h02, W1, 16'h0000);
        step(0, 1, 0, 0, 8'h00, 2'b01, 8'h02, W2, 16'h0001);
        step(0, 1, 0, 0, 8'h00, 2'b00, 8'h03, W2, 16'h0000);
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h03, W3, 16'h0001);

        // Jump from pc=3 to 1.
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h03, W3, 16'h0002);
        step(1, 1, 1, 0, 8'h01, 2'b00, 8'h01, W3, 16'h0000);
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h01, W1, 16'h0001);

        // jmp_inst alone is inert; then jump out of range to 0x10.
        step(1, 0, 1, 0, 8'h10, 2'b10, 8'h01, W1, 16'h0002);
        step(0, 0, 1, 0, 8'h10, 2'b10, 8'h01, W1, 16'h0004);
        step(1, 1, 1, 0, 8'h10, 2'b00, 8'h10, W1, 16'h0000);
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h10, 32'h0, 16'h0001);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h10, 32'h0, 16'h0002);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h11, 32'h0, 16'h0000);
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h11, 32'h0, 16'h0001);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h11, 32'h0, 16'h0002);
        step(1, 1, 1, 0, 8'h03, 2'b00, 8'h03, 32'h0, 16'h0000);
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h03, W3, 16'h0001);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h03, W3, 16'h0002);

        // Overflow guard: walk up to 8000, then forced end with pc wrap 3 -> 0.
        for (int k = 2; k < 16; k++)
            step(1, 0, 0, 0, 8'h00, 2'b10, 8'h03, W3, 16'h0001 << k);
        step(1, 0, 0, 0, 8'h00, 2'b00, 8'h00, W3, 16'h0000);

        // Halt at pc=1 (hlt beats end/jmp), then hold despite toggling inputs.
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h00, W0, 16'h0001);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h00, W0, 16'h0002);
        step(1, 1, 0, 0, 8'h00, 2'b00, 8'h01, W0, 16'h0000);
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h01, W1, 16'h0001);
        step(1, 0, 0, 0, 8'h00, 2'b10, 8'h01, W1, 16'h0002);
        step(1, 1, 1, 1, 8'h02, 2'b11, 8'h01, W1, 16'h0000);
        for (int k = 0; k < 12; k++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                 2'b11, 8'h01, W1, 16'h0000);
        drain();

        // Asynchronous reset mid-cycle out of HALT.
        @(posedge clk);
        #3 reset = 1'b0;
        #1 compare("async_reset", '{st: 2'b00, pc: 8'h00, ir: 32'h0, clks: 16'h0});
        @(posedge clk);
        #2 reset = 1'b1;
        step(1, 0, 0, 0, 8'h00, 2'b01, 8'h00, W0, 16'h0001);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
